// File: rtl/i2c_pkg.sv
// i2c_pkg: constants shared by the I2C slave and the master's debug decoding.
//   I2C_ADDR_W  7-bit bus address width
//   READ/WRITE  values of the R/W bit on the wire
//   ST_*        4-bit state codes exposed on the slave's debug port
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_WR_DATA  = 4'd3;
  localparam logic [3:0] ST_WR_ACK   = 4'd4;
  localparam logic [3:0] ST_RD_DATA  = 4'd5;
  localparam logic [3:0] ST_RD_ACK   = 4'd6;
  localparam logic [3:0] ST_IGNORE   = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_ADDR     = ST_ADDR,
    S_ADDR_ACK = ST_ADDR_ACK,
    S_WR_DATA  = ST_WR_DATA,
    S_WR_ACK   = ST_WR_ACK,
    S_RD_DATA  = ST_RD_DATA,
    S_RD_ACK   = ST_RD_ACK,
    S_IGNORE   = ST_IGNORE
  } i2c_state_e;
endpackage

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: bus + byte-side signals of the I2C slave.
//   sclk, sda_in    serial clock / data as seen on the pins
//   sda_out         open-drain data drive (0 = pull low, 1 = release)
//   rx_data/valid   received byte and its 1-clk strobe
//   tx_data/tx_req  byte to transmit and its 1-clk request
//   addressed, rw   transfer status; state = FSM state for debug
interface i2c_slave_if;
  logic       sclk;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       addressed;
  logic       rw;
  logic [3:0] state;

  modport slave (
    input  sclk, sda_in, tx_data,
    output sda_out, rx_data, rx_valid, tx_req, addressed, rw, state
  );

  modport master (
    output sclk, sda_in, tx_data,
    input  sda_out, rx_data, rx_valid, tx_req, addressed, rw, state
  );
endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: SYNC_STAGES-flop synchronizer for one bus line plus an
// edge-detect flop.
//   clk, rst   system clock, async active-low reset
//   d          raw pin
//   q          synchronized level
//   rise/fall  single-cycle edge strobes on q
// Flops reset to 1 (idle bus level) so reset release never fakes an edge.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise =  q & ~prev_q;
  assign fall = ~q &  prev_q;
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C responder without clock stretching.
//   clk   system clock (>= 8x sclk)
//   rst   async active-low reset
//   bus   i2c_slave_if.slave: pins, rx byte strobe, tx byte request, status
// Detects START/STOP, matches SLAVE_ADDR, ACKs it, then receives bytes
// (write, each ACKed) or transmits bytes (read, continues while master ACKs).
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h2d,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  i2c_slave_if.slave  bus
);
  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .d(bus.sclk), .q(scl_s), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .d(bus.sda_in), .q(sda_s), .rise(sda_rise), .fall(sda_fall)
  );

  // An scl edge in the same sampled cycle masks the sda edge.
  logic scl_edge, start_ev, stop_ev;
  assign scl_edge = scl_rise | scl_fall;
  assign start_ev = sda_fall & scl_s & ~scl_edge;
  assign stop_ev  = sda_rise & scl_s & ~scl_edge;

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       bd_q, bd_d;     // 8th bit seen, waiting for its scl fall
  logic       sda_q, sda_d;
  logic [7:0] rxd_q, rxd_d;
  logic       rxv_q, rxv_d;
  logic       txr_q, txr_d;
  logic       adr_q, adr_d;
  logic       rw_q, rw_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bd_q    <= 1'b0;
      sda_q   <= 1'b1;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      txr_q   <= 1'b0;
      adr_q   <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bd_q    <= bd_d;
      sda_q   <= sda_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      txr_q   <= txr_d;
      adr_q   <= adr_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bd_d    = bd_q;
    sda_d   = sda_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    txr_d   = 1'b0;
    adr_d   = adr_q;
    rw_d    = rw_q;

    if (stop_ev) begin
      state_d = S_IDLE;
      sda_d   = 1'b1;
      adr_d   = 1'b0;
      bd_d    = 1'b0;
    end else if (start_ev) begin
      // Covers repeated START too: any partial byte is dropped here.
      state_d = S_ADDR;
      sda_d   = 1'b1;
      adr_d   = 1'b0;
      cnt_d   = '0;
      bd_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: sda_d = 1'b1;
        S_ADDR: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d = sda_s;
              // sh_q[6:0] now holds the seven address bits
              if (sh_q[6:0] == SLAVE_ADDR) bd_d = 1'b1;
              else                         state_d = S_IGNORE;
            end
          end else if (scl_fall && bd_q) begin
            state_d = S_ADDR_ACK;
            sda_d   = 1'b0;
            adr_d   = 1'b1;
            bd_d    = 1'b0;
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise) begin
            if (rw_q == READ) txr_d = 1'b1;
          end else if (scl_fall) begin
            cnt_d = '0;
            if (rw_q == WRITE) begin
              state_d = S_WR_DATA;
              sda_d   = 1'b1;
            end else begin
              state_d = S_RD_DATA;
              sda_d   = bus.tx_data[7];
              sh_d    = {bus.tx_data[6:0], 1'b0};
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rxd_d = {sh_q[6:0], sda_s};
              rxv_d = 1'b1;
              bd_d  = 1'b1;
            end
          end else if (scl_fall && bd_q) begin
            state_d = S_WR_ACK;
            sda_d   = 1'b0;
            bd_d    = 1'b0;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            state_d = S_WR_DATA;
            sda_d   = 1'b1;
          end
        end
        S_RD_DATA: begin
          // bit7 went out on entry; falls 1..7 shift out the rest, fall 8 releases
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              state_d = S_RD_ACK;
              sda_d   = 1'b1;
              cnt_d   = '0;
            end else begin
              sda_d = sh_q[7];
              sh_d  = {sh_q[6:0], 1'b0};
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) txr_d   = 1'b1;
            else        state_d = S_IGNORE;
          end else if (scl_fall) begin
            // only reachable after an ACK; a NACK already left this state
            state_d = S_RD_DATA;
            sda_d   = bus.tx_data[7];
            sh_d    = {bus.tx_data[6:0], 1'b0};
            cnt_d   = '0;
          end
        end
        S_IGNORE: sda_d = 1'b1;
        default: begin
          state_d = S_IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

  assign bus.sda_out   = sda_q;
  assign bus.rx_data   = rxd_q;
  assign bus.rx_valid  = rxv_q;
  assign bus.tx_req    = txr_q;
  assign bus.addressed = adr_q;
  assign bus.rw        = rw_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with a transaction-level model.
// Expected received bytes and transmit bytes are queued when a transfer is
// issued; a monitor pops them on rx_valid / tx_req.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 6;  // clk cycles per quarter sclk period

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sda_m = 1'b1;
  logic quiet = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   quiet_viol = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_src[$];
  logic [7:0] dat[4];

  i2c_slave_if bus();
  assign bus.sda_in = sda_m & bus.sda_out;  // wired-AND open drain

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h2d), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard side
  initial begin
    bus.tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (quiet && !bus.sda_out) quiet_viol++;
        if (bus.rx_valid && bus.tx_req) begin
          n_cmp++; n_err++;
          $display("FAIL pulse_overlap: rx_valid and tx_req both 1");
        end
        if (bus.rx_valid) begin
          if (exp_rx.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rx_valid: unexpected pulse with rx_data=0x%0h, none expected", bus.rx_data);
          end else chk("rx_data", bus.rx_data, exp_rx.pop_front());
        end
        if (bus.tx_req) begin
          n_cmp++;
          if (tx_src.size() == 0) begin
            n_err++;
            $display("FAIL tx_req: unexpected pulse, got 1 want 0");
          end else bus.tx_data = tx_src.pop_front();
        end
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    bus.sclk = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    bus.sclk = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    bus.sclk = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    bus.sclk = 1'b1; wait_q(); wait_q();
    bus.sclk = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    bus.sclk = 1'b1; wait_q();
    b = bus.sda_in; wait_q();
    bus.sclk = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic last);
    logic b;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
    write_bit(last);
  endtask

  // One full transfer: START, address, n bytes of dat[], STOP.
  task automatic xfer(input logic [7:0] a, input int n);
    logic hit, ack;
    logic [7:0] b;
    int qv0;
    hit = (a[7:1] == 7'h2d);
    for (int i = 0; i < n; i++)
      if (hit) begin
        if (a[0] == WRITE) exp_rx.push_back(dat[i]);
        else               tx_src.push_back(dat[i]);
      end
    qv0 = quiet_viol;
    quiet = !hit;
    i2c_start();
    send_byte(a, ack);
    chk("addr_ack", {31'b0, ack}, {31'b0, !hit});
    if (!hit) begin
      chk("miss_state", {28'b0, bus.state}, {28'b0, ST_IGNORE});
      for (int i = 0; i < n; i++) begin
        send_byte(dat[i], ack);
        chk("miss_nack", {31'b0, ack}, 32'd1);
      end
    end else begin
      chk("addressed", {31'b0, bus.addressed}, 32'd1);
      chk("rw", {31'b0, bus.rw}, {31'b0, a[0]});
      if (a[0] == WRITE) begin
        for (int i = 0; i < n; i++) begin
          send_byte(dat[i], ack);
          chk("wr_ack", {31'b0, ack}, 32'd0);
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          recv_byte(b, i == n - 1);
          chk("rd_byte", {24'b0, b}, {24'b0, dat[i]});
        end
        chk("nack_state", {28'b0, bus.state}, {28'b0, ST_IGNORE});
        chk("nack_sda", {31'b0, bus.sda_out}, 32'd1);
      end
    end
    i2c_stop();
    quiet = 1'b0;
    if (!hit) chk("miss_quiet", quiet_viol - qv0, 32'd0);
    chk("stop_state", {28'b0, bus.state}, {28'b0, ST_IDLE});
    chk("stop_addressed", {31'b0, bus.addressed}, 32'd0);
    chk("rx_left", exp_rx.size(), 32'd0);
    chk("tx_left", tx_src.size(), 32'd0);
  endtask

  initial begin
    logic ack, b;
    logic [7:0] a;
    bus.sclk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_out",   {31'b0, bus.sda_out},   32'd1);
    chk("rst_rx_data",   {24'b0, bus.rx_data},   32'd0);
    chk("rst_rx_valid",  {31'b0, bus.rx_valid},  32'd0);
    chk("rst_tx_req",    {31'b0, bus.tx_req},    32'd0);
    chk("rst_addressed", {31'b0, bus.addressed}, 32'd0);
    chk("rst_rw",        {31'b0, bus.rw},        32'd0);
    chk("rst_state",     {28'b0, bus.state},     32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 1: write one byte
    dat[0] = 8'hc3; xfer(8'h5a, 1);
    chk("t1_rx_hold", {24'b0, bus.rx_data}, 32'hc3);
    // 2: single read, NACK
    dat[0] = 8'ha5; xfer(8'h5b, 1);
    // 3: two-byte read, ACK then NACK
    dat[0] = 8'h11; dat[1] = 8'h22; xfer(8'h5b, 2);
    // 4: foreign address
    dat[0] = 8'h99; xfer(8'h40, 1);
    chk("t4_rx_hold", {24'b0, bus.rx_data}, 32'hc3);

    // 5: partial write byte cut by repeated START, then read
    dat[0] = 8'h3c;
    tx_src.push_back(dat[0]);
    i2c_start();
    send_byte(8'h5a, ack);
    chk("t5_addr_ack", {31'b0, ack}, 32'd0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    i2c_start();
    chk("t5_rs_state", {28'b0, bus.state}, {28'b0, ST_ADDR});
    chk("t5_rs_addressed", {31'b0, bus.addressed}, 32'd0);
    send_byte(8'h5b, ack);
    chk("t5_rd_ack", {31'b0, ack}, 32'd0);
    chk("t5_rw", {31'b0, bus.rw}, 32'd1);
    recv_byte(a, 1'b1);
    chk("t5_rd_byte", {24'b0, a}, 32'h3c);
    i2c_stop();
    chk("t5_rx_left", exp_rx.size(), 32'd0);
    chk("t5_rx_hold", {24'b0, bus.rx_data}, 32'hc3);

    // 6: async reset while slave pulls sda low mid-read
    tx_src.push_back(8'h00);
    i2c_start();
    send_byte(8'h5b, ack);
    read_bit(b); read_bit(b); read_bit(b);
    chk("t6_pre_sda", {31'b0, bus.sda_out}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_sda", {31'b0, bus.sda_out}, 32'd1);
    chk("t6_rst_state", {28'b0, bus.state}, 32'd0);
    bus.sclk = 1'b1; sda_m = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    wait_q();
    dat[0] = 8'h5e; xfer(8'h5a, 1);

    // randomized transfers
    for (int t = 0; t < 16; t++) begin
      int kind, n;
      kind = $urandom_range(0, 3);
      n    = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      if (kind == 0)      a = 8'h5a;
      else if (kind == 1) a = 8'h5b;
      else                a = 8'($urandom);
      xfer(a, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
